l_array_loader: RTL and testbench

L_ARRAY_LOADER -- requirements
Module: l_array_loader

---
 rtl/l_array_loader.sv | 118 +++++++++++
 tb/tb_l_array_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/l_array_loader.sv
// l_array_loader: clears the L array, then folds the key into it byte by byte, highest byte first.
module l_array_loader #(
  parameter int W = 32,
  parameter int B_MAX = 16,
  localparam int U = W / 8,
  localparam int C_MAX = (B_MAX + U - 1) / U > 1 ? (B_MAX + U - 1) / U : 1,
  localparam int KL = $clog2(B_MAX + 1),
  localparam int BA = B_MAX > 1 ? $clog2(B_MAX) : 1,
  localparam int CA = C_MAX > 1 ? $clog2(C_MAX) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [KL-1:0] key_len_i,
  output logic [BA-1:0] key_addr_o,
  input  logic [7:0]    key_byte_i,
  output logic [CA-1:0] l_addr_o,
  input  logic [W-1:0]  l_rd_data_i,
  output logic [W-1:0]  l_wr_data_o,
  output logic          l_we_o,
  output logic [CA:0]   c_words_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int CW = CA + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, ADDR, READ, OPER, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [KL-1:0] b_q, b_d, bl;
  logic [CA:0] c_q, c_d, cl;
  logic [BA-1:0] key_addr_q, key_addr_d, nxt_i;
  logic [CA-1:0] l_addr_q, l_addr_d;
  logic [W-1:0] wr_q, wr_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d;
  assign bl = key_len_i > KL'(B_MAX) ? KL'(B_MAX) : key_len_i;
  assign cl = bl == '0 ? CW'(1) : CW'((32'(bl) + U - 1) / U);
  // next byte index: top byte when leaving CLEAR, otherwise one below the current
  assign nxt_i = state_q == CLEAR ? BA'(b_q - 1'b1) : key_addr_q - 1'b1;
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    c_d = c_q;
    key_addr_d = key_addr_q;
    l_addr_d = l_addr_q;
    wr_d = wr_q;
    we_d = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CLEAR;
        b_d = bl;
        c_d = cl;
        l_addr_d = '0;
        wr_d = '0;
        we_d = 1'b1;
        busy_d = 1'b1;
      end
      CLEAR: if ({1'b0, l_addr_q} == c_q - 1'b1) begin
        state_d = b_q != '0 ? ADDR : DONE;
        key_addr_d = b_q != '0 ? nxt_i : key_addr_q;
        l_addr_d = b_q != '0 ? CA'(nxt_i >> $clog2(U)) : l_addr_q;
        done_d = b_q == '0;
        busy_d = b_q != '0;
      end else begin
        l_addr_d = l_addr_q + 1'b1;
        we_d = 1'b1;
      end
      ADDR: state_d = READ;
      READ: begin
        state_d = OPER;
        wr_d = {l_rd_data_i[W-9:0], l_rd_data_i[W-1:W-8]} + W'(key_byte_i);
      end
      OPER: begin
        state_d = WRITE;
        we_d = 1'b1;
      end
      WRITE: begin
        state_d = key_addr_q == '0 ? DONE : ADDR;
        key_addr_d = key_addr_q == '0 ? key_addr_q : nxt_i;
        l_addr_d = key_addr_q == '0 ? l_addr_q : CA'(nxt_i >> $clog2(U));
        done_d = key_addr_q == '0;
        busy_d = key_addr_q != '0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      b_q <= '0;
      c_q <= '0;
      key_addr_q <= '0;
      l_addr_q <= '0;
      wr_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      c_q <= c_d;
      key_addr_q <= key_addr_d;
      l_addr_q <= l_addr_d;
      wr_q <= wr_d;
      we_q <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign key_addr_o = key_addr_q;
  assign l_addr_o = l_addr_q;
  assign l_wr_data_o = wr_q;
  assign l_we_o = we_q;
  assign c_words_o = c_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_l_array_loader.sv
// tb_l_array_loader: drives key/L memory models around two loaders (W=32 and W=16) and scores every write.
module tb_l_array_loader;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  int cyc = 0, s0 = 0, checks = 0, failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic start, we, busy, done;
  logic [4:0] key_len;
  logic [3:0] key_addr;
  logic [7:0] key_byte;
  logic [1:0] l_addr;
  logic [31:0] rd, wr;
  logic [2:0] cw;
  l_array_loader #(.W(32), .B_MAX(16)) dut (.clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_len_i(key_len),
    .key_addr_o(key_addr), .key_byte_i(key_byte), .l_addr_o(l_addr), .l_rd_data_i(rd), .l_wr_data_o(wr),
    .l_we_o(we), .c_words_o(cw), .busy_o(busy), .done_o(done));
  logic start2, we2, busy2, done2;
  logic [4:0] key_len2;
  logic [3:0] key_addr2, cw2;
  logic [7:0] key_byte2;
  logic [2:0] l_addr2;
  logic [15:0] rd2, wr2;
  l_array_loader #(.W(16), .B_MAX(16)) dut16 (.clk_i(clk), .rst_ni(rst_n), .start_i(start2), .key_len_i(key_len2),
    .key_addr_o(key_addr2), .key_byte_i(key_byte2), .l_addr_o(l_addr2), .l_rd_data_i(rd2), .l_wr_data_o(wr2),
    .l_we_o(we2), .c_words_o(cw2), .busy_o(busy2), .done_o(done2));
  logic [7:0] kmem [16];
  logic [31:0] lmem [4];
  int wa[$];
  logic [31:0] wd[$];
  logic [7:0] kmem2 [16];
  logic [15:0] lmem2 [8];
  int wa2[$];
  logic [15:0] wd2[$];
  always @(posedge clk) begin
    key_byte <= kmem[key_addr];
    rd <= lmem[l_addr];
    if (we) begin
      lmem[l_addr] <= wr;
      wa.push_back(int'(l_addr));
      wd.push_back(wr);
    end
    key_byte2 <= kmem2[key_addr2];
    rd2 <= lmem2[l_addr2];
    if (we2) begin
      lmem2[l_addr2] <= wr2;
      wa2.push_back(int'(l_addr2));
      wd2.push_back(wr2);
    end
  end
  // word i/4 after key bytes i..b-1 have been folded in: key bytes little-endian from byte i up to the word's end
  function automatic logic [31:0] word_from(int i, int b);
    logic [31:0] v;
    int hi;
    v = 0;
    hi = (i / 4 + 1) * 4;
    if (hi > b) hi = b;
    for (int k = i; k < hi; k++) v = v | (32'(kmem[k]) << (8 * (k - i)));
    return v;
  endfunction
  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({key_addr, l_addr, wr, we, cw, busy, done} !== '0)
      begin failures++; $display("FAIL reset32 outputs got %h required 0", {key_addr, l_addr, wr, we, cw, busy, done}); end
    checks++;
    if ({key_addr2, l_addr2, wr2, we2, cw2, busy2, done2} !== '0)
      begin failures++; $display("FAIL reset16 outputs got %h required 0", {key_addr2, l_addr2, wr2, we2, cw2, busy2, done2}); end
    repeat (2) @(negedge clk);
    checks++;
    if ({we, busy, done, cw} !== '0) begin failures++; $display("FAIL reset_hold got %h required 0", {we, busy, done, cw}); end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({we, busy, done} !== '0) begin failures++; $display("FAIL idle_after_reset got %b required 000", {we, busy, done}); end
  endtask
  task automatic test_job(input string nm, input int kl, input bit pulse);
    int b, c, n, e;
    int ea[$];
    logic [31:0] ed[$];
    b = kl > 16 ? 16 : kl;
    c = b == 0 ? 1 : (b + 3) / 4;
    for (int j = 0; j < c; j++) begin ea.push_back(j); ed.push_back(0); end
    for (int i = b - 1; i >= 0; i--) begin ea.push_back(i / 4); ed.push_back(word_from(i, b)); end
    wa.delete();
    wd.delete();
    @(negedge clk);
    start = 1;
    key_len = 5'(kl);
    s0 = cyc;
    @(negedge clk);
    start = 0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got %b required 1", nm, busy); end
    e = -1;
    for (int k = 0; k < 200 && e < 0; k++) begin
      n = cyc - s0 - 1;
      if (done === 1'b1) e = n;
      else begin
        if (pulse && n == 9) begin start = 1; key_len = 5'd3; end
        if (pulse && n == 10) start = 0;
        @(negedge clk);
      end
    end
    checks++;
    if (e != c + 4 * b) begin failures++; $display("FAIL %s done_edge got %0d required %0d", nm, e, c + 4 * b); end
    checks++;
    if (cw !== 3'(c)) begin failures++; $display("FAIL %s c_words got %0d required %0d", nm, cw, c); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got %b required 0", nm, busy); end
    checks++;
    if (wa.size() != ea.size()) begin failures++; $display("FAIL %s write_count got %0d required %0d", nm, wa.size(), ea.size()); end
    for (int k = 0; k < wa.size() && k < ea.size(); k++) begin
      checks++;
      if (wa[k] != ea[k] || wd[k] !== ed[k])
        begin failures++; $display("FAIL %s write%0d got L[%0d]=%h required L[%0d]=%h", nm, k, wa[k], wd[k], ea[k], ed[k]); end
    end
    for (int j = 0; j < c; j++) begin
      checks++;
      if (lmem[j] !== word_from(4 * j, b))
        begin failures++; $display("FAIL %s final_L%0d got %h required %h", nm, j, lmem[j], word_from(4 * j, b)); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cw !== 3'(c))
      begin failures++; $display("FAIL %s after_done got done=%b c=%0d required done=0 c=%0d", nm, done, cw, c); end
  endtask
  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 16; k++) kmem[k] = 8'($urandom);
      for (int j = 0; j < 4; j++) lmem[j] = $urandom;
      test_job("random", int'($urandom_range(0, 31)), 1'b0);
    end
    for (int k = 0; k < 16; k++) kmem[k] = 8'(k);
  endtask
  task automatic test_reset_midjob();
    int n, nw;
    bit hit;
    wa.delete();
    wd.delete();
    @(negedge clk);
    start = 1;
    key_len = 5'd16;
    s0 = cyc;
    @(negedge clk);
    start = 0;
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      n = cyc - s0 - 1;
      if (we === 1'b1 && n >= 4) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midjob_find_write got none required a WRITE cycle"); end
    nw = wa.size();
    rst_n = 0;
    #1;
    checks++;
    if ({we, busy, done, cw, l_addr, key_addr, wr} !== '0)
      begin failures++; $display("FAIL midjob_async_reset got %h required 0", {we, busy, done, cw, l_addr, key_addr, wr}); end
    repeat (4) @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (wa.size() != nw || busy !== 1'b0)
      begin failures++; $display("FAIL midjob_no_writes got writes=%0d busy=%b required writes=%0d busy=0", wa.size(), busy, nw); end
    test_job("restart", 16, 1'b0);
  endtask
  task automatic test_w16();
    int e, n;
    int ea[5] = '{0, 1, 1, 0, 0};
    logic [15:0] ed[5] = '{16'h0000, 16'h0000, 16'h00CC, 16'h00BB, 16'hBBAA};
    kmem2[0] = 8'hAA;
    kmem2[1] = 8'hBB;
    kmem2[2] = 8'hCC;
    for (int j = 0; j < 8; j++) lmem2[j] = 16'($urandom);
    wa2.delete();
    wd2.delete();
    @(negedge clk);
    start2 = 1;
    key_len2 = 5'd3;
    s0 = cyc;
    @(negedge clk);
    start2 = 0;
    e = -1;
    for (int k = 0; k < 100 && e < 0; k++) begin
      n = cyc - s0 - 1;
      if (done2 === 1'b1) e = n;
      else @(negedge clk);
    end
    checks++;
    if (e != 14) begin failures++; $display("FAIL w16 done_edge got %0d required 14", e); end
    checks++;
    if (cw2 !== 4'd2) begin failures++; $display("FAIL w16 c_words got %0d required 2", cw2); end
    checks++;
    if (wa2.size() != 5) begin failures++; $display("FAIL w16 write_count got %0d required 5", wa2.size()); end
    for (int k = 0; k < 5 && k < wa2.size(); k++) begin
      checks++;
      if (wa2[k] != ea[k] || wd2[k] !== ed[k])
        begin failures++; $display("FAIL w16 write%0d got L[%0d]=%h required L[%0d]=%h", k, wa2[k], wd2[k], ea[k], ed[k]); end
    end
  endtask
  initial begin
    start = 0;
    key_len = 0;
    start2 = 0;
    key_len2 = 0;
    for (int k = 0; k < 16; k++) begin kmem[k] = 8'(k); kmem2[k] = 0; end
    for (int j = 0; j < 4; j++) lmem[j] = 32'hDEADBEEF;
    for (int j = 0; j < 8; j++) lmem2[j] = 16'hBEEF;
    test_reset();
    test_job("full16", 16, 1'b0);
    test_job("zero", 0, 1'b0);
    test_job("partial5", 5, 1'b0);
    test_job("clamp20", 20, 1'b1);
    test_random();
    test_reset_midjob();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
